// File: rtl/zeroskip_pkg.sv
// Shared types and helpers for the zero-skip merge pipe.
//   ratio_mode_t   : merge density mode (1, 2 or 4 beats per output)
//   decode_ratio   : maps the raw 2-bit ratio select onto a mode (3 -> half)
//   beats_per_mode : number of input beats merged into one output
package zeroskip_pkg;

  // Encoding equals log2(beats per output); the top relies on this to
  // derive the per-beat slot count with a shift.
  typedef enum logic [1:0] {
    RATIO_HALF   = 2'd0,
    RATIO_QUAR   = 2'd1,
    RATIO_EIGHTH = 2'd2
  } ratio_mode_t;

  function automatic ratio_mode_t decode_ratio(input logic [1:0] sel);
    case (sel)
      2'd1:    return RATIO_QUAR;
      2'd2:    return RATIO_EIGHTH;
      default: return RATIO_HALF;
    endcase
  endfunction

  function automatic logic [2:0] beats_per_mode(input ratio_mode_t mode);
    case (mode)
      RATIO_QUAR:   return 3'd2;
      RATIO_EIGHTH: return 3'd4;
      default:      return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/zeroskip_compact.sv
// Mask-driven compaction of one activation half-group.
//   mask : GROUP_SIZE-bit zero/non-zero mask, bit j qualifies data element j
//   data : GROUP_SIZE activations of DATA_W bits, element 0 in the low bits
//   k    : number of output slots in use this beat (<= NZ_MAX)
//   comp : first k qualified elements in ascending index, zero-filled above
//   over : more mask bits set than k (excess elements are dropped)
module zeroskip_compact #(
  parameter int GROUP_SIZE = 16,
  parameter int NZ_MAX     = 8,
  parameter int DATA_W     = 8
) (
  input  logic [GROUP_SIZE-1:0]          mask,
  input  logic [GROUP_SIZE*DATA_W-1:0]   data,
  input  logic [$clog2(NZ_MAX+1)-1:0]    k,
  output logic [NZ_MAX*DATA_W-1:0]       comp,
  output logic                           over
);

  int n;

  // NOTE: combinational blocks use blocking assignments and give every
  // written variable a default first, so no latch is inferred.
  always_comb begin
    comp = '0;
    n    = 0;
    for (int j = 0; j < GROUP_SIZE; j++) begin
      if (mask[j]) begin
        if (n < NZ_MAX && n < int'(k)) begin
          comp[n*DATA_W +: DATA_W] = data[j*DATA_W +: DATA_W];
        end
        n = n + 1;
      end
    end
  end

  assign over = ($countones(mask) > int'(k));

endmodule

// File: rtl/zeroskip_merge_pipe.sv
// Zero-skip front end: compacts activation halves under per-group masks and
// merges 1, 2 or 4 beats into one dense row set for the MAC array.
//   clk, a_rst_n           : clock, asynchronous active-low reset
//   enable, flush          : acceptance gate, synchronous partial-merge discard
//   ratio_sel              : 0=1 beat, 1=2 beats, 2=4 beats, 3=1 beat
//   znz_din / act_din      : masks (2M groups) and activations (two halves)
//   *_vld_i / *_rdy_o      : input handshake (both rdy outputs identical)
//   act_enc_dout/_vld_o/_rdy_i : merged output rows and handshake
//   overflow_o             : sticky, a mask exceeded the per-beat slot count
//   busy_o                 : a partial merge is in progress
module zeroskip_merge_pipe
  import zeroskip_pkg::*;
#(
  parameter int M          = 16,
  parameter int GROUP_SIZE = 16,
  parameter int DATA_W     = 8,
  parameter int NZ_MAX     = 8,
  parameter int MAX_MERGE  = 4
) (
  input  logic                                clk,
  input  logic                                a_rst_n,
  input  logic                                enable,
  input  logic                                flush,
  input  logic [1:0]                          ratio_sel,
  input  logic [2*M*GROUP_SIZE-1:0]           znz_din,
  input  logic                                znz_din_vld_i,
  output logic                                znz_din_rdy_o,
  input  logic [2*GROUP_SIZE*DATA_W-1:0]      act_din,
  input  logic                                act_din_vld_i,
  output logic                                act_din_rdy_o,
  output logic [M*2*NZ_MAX*DATA_W-1:0]        act_enc_dout,
  output logic                                act_enc_vld_o,
  input  logic                                act_enc_rdy_i,
  output logic                                overflow_o,
  output logic                                busy_o
);

  localparam int KW    = $clog2(NZ_MAX + 1);
  localparam int CW    = $clog2(MAX_MERGE);
  localparam int ROW_E = 2 * NZ_MAX;
  localparam int HALF_W = GROUP_SIZE * DATA_W;

  logic [CW-1:0]              beat_cnt;
  ratio_mode_t                mode_q;
  ratio_mode_t                mode_eff;
  logic [KW-1:0]              k;
  logic                       last_beat;
  logic                       rdy;
  logic                       accept;
  logic [M*ROW_E*DATA_W-1:0]  acc_q;
  logic [M*ROW_E*DATA_W-1:0]  acc_next;
  logic [NZ_MAX*DATA_W-1:0]   comp [2*M];
  logic [2*M-1:0]             over;
  int                         base;

  // Beat 0 takes the live select; later beats of the group use the latched one.
  assign mode_eff  = (beat_cnt == '0) ? decode_ratio(ratio_sel) : mode_q;
  assign k         = KW'(NZ_MAX >> mode_eff);
  assign last_beat = (int'(beat_cnt) + 1 == int'(beats_per_mode(mode_eff)));

  // Only the last beat needs the output register free; earlier beats go
  // into the accumulator and may proceed while the output is stalled.
  assign rdy = enable && !flush && (!last_beat || !act_enc_vld_o || act_enc_rdy_i);
  assign znz_din_rdy_o = rdy;
  assign act_din_rdy_o = rdy;
  assign accept = rdy && znz_din_vld_i && act_din_vld_i;
  assign busy_o = (beat_cnt != '0);

  // Groups 0..M-1 compact half A, groups M..2M-1 compact half B.
  for (genvar g = 0; g < 2*M; g++) begin : g_compact
    zeroskip_compact #(
      .GROUP_SIZE (GROUP_SIZE),
      .NZ_MAX     (NZ_MAX),
      .DATA_W     (DATA_W)
    ) u_compact (
      .mask (znz_din[g*GROUP_SIZE +: GROUP_SIZE]),
      .data (act_din[(g/M)*HALF_W +: HALF_W]),
      .k    (k),
      .comp (comp[g]),
      .over (over[g])
    );
  end

  // Row i of beat b: {compB[K-1:0], compA[K-1:0]} at element offset b*2K.
  always_comb begin
    acc_next = acc_q;
    base     = int'(beat_cnt) * 2 * int'(k);
    for (int i = 0; i < M; i++) begin
      for (int c = 0; c < NZ_MAX; c++) begin
        if (c < int'(k)) begin
          acc_next[(i*ROW_E + base + c)*DATA_W +: DATA_W] =
            comp[i][c*DATA_W +: DATA_W];
          acc_next[(i*ROW_E + base + int'(k) + c)*DATA_W +: DATA_W] =
            comp[M+i][c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // NOTE: the accumulator and output data are reset as well as the control
  // bits, because a zero row set is the defined state after reset.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      beat_cnt   <= '0;
      mode_q     <= RATIO_HALF;
      acc_q      <= '0;
      overflow_o <= 1'b0;
    end else if (flush) begin
      beat_cnt   <= '0;
      acc_q      <= '0;
      overflow_o <= 1'b0;
    end else if (accept) begin
      if (beat_cnt == '0) mode_q <= mode_eff;
      if (|over) overflow_o <= 1'b1;
      if (last_beat) begin
        beat_cnt <= '0;
        acc_q    <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        acc_q    <= acc_next;
      end
    end
  end

  // Output register: a new word may load in the same cycle the old one pops.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      act_enc_dout  <= '0;
      act_enc_vld_o <= 1'b0;
    end else if (accept && last_beat) begin
      act_enc_dout  <= acc_next;
      act_enc_vld_o <= 1'b1;
    end else if (act_enc_vld_o && act_enc_rdy_i) begin
      act_enc_vld_o <= 1'b0;
    end
  end

endmodule

// File: doc/zeroskip_merge_pipe.md
Name: zeroskip_merge_pipe

Overview:
- Next-generation zero-skip front end for the MAC array.
- Compacts activation bytes under a zero/non-zero (znz) mask per row group.
- Merges 1, 2 or 4 input beats into one dense output row set, chosen by a runtime ratio mode (50%, 25%, 12.5% density).
- Sits between the activation/znz buffers and the MAC operand register, with full valid/ready backpressure on both sides.

Parameters:
- M, 16, number of output rows (one per MAC row); also half the number of mask groups.
- GROUP_SIZE, 16, activations per half-group and mask width.
- DATA_W, 8, activation element width.
- NZ_MAX, 8, max compacted elements per half-group per output row; must be divisible by 4.
- MAX_MERGE, 4, max beats merged per output; fixed to 4 in this generation.

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- enable  in  1  gates input acceptance and merge state advance
- flush  in  1  synchronous discard of the partial merge and overflow flag
- ratio_sel  in  2  0=1 beat (50%), 1=2 beats (25%), 2=4 beats (12.5%), 3=treated as 0
- znz_din  in  2M x GROUP_SIZE  masks; groups 0..M-1 use act half A, groups M..2M-1 use act half B
- znz_din_vld_i  in  1  mask valid
- znz_din_rdy_o  out  1  mask ready
- act_din  in  2*GROUP_SIZE x DATA_W  activations; half A = [GROUP_SIZE-1:0], half B = upper
- act_din_vld_i  in  1  activation valid
- act_din_rdy_o  out  1  activation ready
- act_enc_dout  out  M x 2*NZ_MAX x DATA_W  merged compacted rows
- act_enc_vld_o  out  1  output valid
- act_enc_rdy_i  in  1  output ready
- overflow_o  out  1  sticky: a mask had more set bits than the per-beat slot K
- busy_o  out  1  partial merge in progress (beat_cnt != 0)

Behaviour:
- Reset: beat_cnt=0, accumulator=0, act_enc_dout=0, act_enc_vld_o=0, overflow_o=0, busy_o=0, latched mode=0.
- Both rdy outputs are the same signal: rdy = enable && !flush && (!last_beat || !act_enc_vld_o || act_enc_rdy_i). rdy never depends on the input valids.
- A beat is accepted when znz_din_vld_i && act_din_vld_i && rdy. One valid without the other is not accepted.
- Mode latch: ratio_sel is sampled at acceptance of beat 0 and held until the group completes. Changes mid-group are ignored.
- Beats per group B = 1, 2, 4 by mode. K = NZ_MAX/B.
- Compaction, per group g: keep the set-mask positions in ascending index, take the first K, zero-fill the rest. The overflow flag sets if popcount(mask) > K; elements beyond K are dropped.
- Per row i, beat b forms chunk = {compB[i][K-1:0], compA[i][K-1:0]} (2K elements) and writes it at element offset b*2K. Beat 0 occupies the lowest elements.
- Non-last beats write the accumulator. On the last beat, the accumulator plus the final chunk load act_enc_dout, act_enc_vld_o is set, and the accumulator clears.
- Latency: last beat accepted at edge t gives act_enc_vld_o=1 after edge t. Mode 0 with continuous valid/ready sustains 1 output per cycle.
- Output: act_enc_vld_o stays high and act_enc_dout stays stable until act_enc_rdy_i. Output handshake is honoured regardless of enable/flush. Simultaneous output pop and new last-beat load: the new data loads and vld stays 1.
- enable=0: no acceptance, beat_cnt/accumulator/overflow frozen.
- flush=1: beat_cnt=0, accumulator=0, overflow_o=0, no beat accepted that cycle. A pending output is not dropped.
- beat_cnt wraps to 0 after beat B-1. busy_o = (beat_cnt != 0).
- Asynchronous reset mid-merge discards everything and returns to the reset state.

Decomposition:
- Package zeroskip_pkg: ratio_mode_t enum (RATIO_HALF, RATIO_QUAR, RATIO_EIGHTH) and a beats-per-mode function.
- Sub-module zeroskip_compact (GROUP_SIZE, NZ_MAX, DATA_W): combinational mask-driven compaction plus popcount>K flag, with K as an input. Instantiated 2M times.

Test Plan:
- Mode 0, all masks 0x00FF, act half A = 1..16, half B = 17..32, rdy_i=1 -> next cycle every row = {24..17, 8..1} (element 0 = 1), 1 output per cycle over 8 back-to-back beats.
- Mode 1, masks 0x000F, two beats with acts 1..32 then 101..132 -> one output, row elements 0..7 = {1,2,3,4,17,18,19,20}, elements 8..15 = {101..104,117..120}; vld only after 2nd beat.
- Mode 2, mask 0x0007 (3 > K=2), four beats -> each chunk keeps the first 2 set elements, overflow_o=1 until flush.
- Output stall: act_enc_rdy_i=0 with vld high -> rdy_o stays 0 on the next last beat, non-last beats still accepted, dout stable; release -> pending word pops, new word loads the following cycle.
- flush after beat 1 of a mode-2 group -> busy_o=0, next group restarts at offset 0, an already-valid output is still delivered.
- ratio_sel toggled 1->0 mid-group -> group completes as 2 beats, and the new mode applies from the next beat 0.
